// File: rtl/pwl_fma_sched.sv
// pwl_fma_sched
//   Shares one pipelined half-precision FMA (y = k*x + b) across the lanes of
//   a piecewise-linear exp() stage. A vector of N x values is accepted, each
//   lane picks (k, b) from an 8-entry table by a raw bit field of x, lanes are
//   issued one per cycle, in-order results are collected and returned as a vector.
//
// Ports
//   aclk, aresetn            clock, synchronous active-low reset
//   in_valid/in_ready/in_x   input vector handshake, lane i = in_x[i*W +: W]
//   out_valid/out_ready/out_y result vector handshake, same lane packing
//   cfg_we/cfg_addr/cfg_k/cfg_b  coefficient table write (accepted only in IDLE)
//   cfg_busy                 high whenever the scheduler is not IDLE
//   fma_valid/fma_a/fma_b/fma_c  registered issue port (a = k, b = x, c = b)
//   fma_res_valid/fma_res    in-order FMA results, no backpressure
//   err_timeout/err_cfg/err_extra  sticky error flags, cleared only by reset
//
// state | meaning
// ------+---------------------------------------------------------------
// FLUSH | discard results still in flight from before reset
// IDLE  | ready for a vector; table writes allowed
// ISSUE | one lane per cycle to the FMA, results may already return
// DRAIN | all lanes issued, waiting for the remaining results
// DONE  | result vector held until out_ready
module pwl_fma_sched #(
  parameter int N        = 10,
  parameter int W        = 16,
  parameter int SEG_BITS = 3,
  parameter int SEG_LSB  = 10,
  parameter int FMA_LAT  = 6,
  parameter int TIMEOUT  = 64
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*W-1:0]      in_x,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N*W-1:0]      out_y,
  input  logic                cfg_we,
  input  logic [SEG_BITS-1:0] cfg_addr,
  input  logic [W-1:0]        cfg_k,
  input  logic [W-1:0]        cfg_b,
  output logic                cfg_busy,
  output logic                fma_valid,
  output logic [W-1:0]        fma_a,
  output logic [W-1:0]        fma_b,
  output logic [W-1:0]        fma_c,
  input  logic                fma_res_valid,
  input  logic [W-1:0]        fma_res,
  output logic                err_timeout,
  output logic                err_cfg,
  output logic                err_extra
);

  localparam int DEPTH = 1 << SEG_BITS;
  localparam int IW    = (N > 1) ? $clog2(N) : 1;
  localparam int CW    = $clog2(N + 1);
  localparam int FW    = (FMA_LAT > 0) ? $clog2(FMA_LAT + 1) : 1;
  localparam int TW    = $clog2(TIMEOUT + 1);

  localparam logic [IW-1:0] IDX_LAST   = IW'(N - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(N - 1);
  localparam logic [CW-1:0] CNT_FULL   = CW'(N);
  localparam logic [FW-1:0] FLUSH_INIT = FW'(FMA_LAT);
  localparam logic [TW-1:0] TO_INIT    = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_FLUSH,
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]        k_tab [DEPTH];
  logic [W-1:0]        b_tab [DEPTH];
  logic [W-1:0]        x_q   [N];
  logic [W-1:0]        y_q   [N];
  logic [IW-1:0]       idx;
  logic [CW-1:0]       cnt;
  logic [FW-1:0]       flush_cnt;
  logic [TW-1:0]       to_cnt;

  logic                accept;
  logic                counting;
  logic                res_take;
  logic                last_res;
  logic                flush_done;
  logic                timeout_hit;
  logic [W-1:0]        x_cur;
  logic [SEG_BITS-1:0] seg_cur;

  assign in_ready    = (state == S_IDLE);
  assign cfg_busy    = (state != S_IDLE);
  assign accept      = in_valid && in_ready;
  assign counting    = (state == S_ISSUE) || (state == S_DRAIN);
  assign res_take    = fma_res_valid && counting && (cnt != CNT_FULL);
  assign last_res    = res_take && (cnt == CNT_LAST);
  assign flush_done  = (flush_cnt <= FW'(1));
  // A result arriving in the terminal cycle wins over the timeout.
  assign timeout_hit = (state == S_DRAIN) && !res_take && (to_cnt == TW'(1));

  assign x_cur   = x_q[idx];
  assign seg_cur = x_cur[SEG_LSB +: SEG_BITS];

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= S_FLUSH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FLUSH: if (flush_done) state_nxt = S_IDLE;
      S_IDLE:  if (accept) state_nxt = S_ISSUE;
      // The final result can land before the last issue cycle is left
      // behind only with very short FMA latency; both exits are covered.
      S_ISSUE: begin
        if (last_res)             state_nxt = S_DONE;
        else if (idx == IDX_LAST) state_nxt = S_DRAIN;
      end
      S_DRAIN: if (last_res || timeout_hit) state_nxt = S_DONE;
      S_DONE:  if (out_valid && out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_FLUSH;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      flush_cnt   <= FLUSH_INIT;
      to_cnt      <= TO_INIT;
      idx         <= '0;
      cnt         <= '0;
      out_valid   <= 1'b0;
      fma_valid   <= 1'b0;
      fma_a       <= '0;
      fma_b       <= '0;
      fma_c       <= '0;
      err_timeout <= 1'b0;
      err_cfg     <= 1'b0;
      err_extra   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        k_tab[i] <= '0;
        b_tab[i] <= '0;
      end
      for (int i = 0; i < N; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      if (state == S_FLUSH && !flush_done) begin
        flush_cnt <= flush_cnt - FW'(1);
      end

      // The table is read only from ISSUE onward, so a write on the
      // acceptance edge is seen by the vector being accepted.
      if (cfg_we) begin
        if (state == S_IDLE) begin
          k_tab[cfg_addr] <= cfg_k;
          b_tab[cfg_addr] <= cfg_b;
        end else begin
          err_cfg <= 1'b1;
        end
      end

      if (accept) begin
        for (int i = 0; i < N; i++) begin
          x_q[i] <= in_x[i*W +: W];
        end
        idx <= '0;
        cnt <= '0;
      end

      fma_valid <= (state == S_ISSUE);
      if (state == S_ISSUE) begin
        fma_a <= k_tab[seg_cur];
        fma_b <= x_cur;
        fma_c <= b_tab[seg_cur];
        idx   <= idx + IW'(1);
      end

      if (res_take) begin
        y_q[cnt] <= fma_res;
        cnt      <= cnt + CW'(1);
      end

      if (state == S_ISSUE || res_take) begin
        to_cnt <= TO_INIT;
      end else if (state == S_DRAIN) begin
        to_cnt <= to_cnt - TW'(1);
      end

      if (last_res || timeout_hit) begin
        out_valid <= 1'b1;
      end else if (state == S_DONE && out_ready) begin
        out_valid <= 1'b0;
      end

      if (timeout_hit) begin
        err_timeout <= 1'b1;
      end

      // Results outside a collection window are dropped; FLUSH discards silently.
      if (fma_res_valid &&
          (state == S_IDLE || state == S_DONE || (counting && cnt == CNT_FULL))) begin
        err_extra <= 1'b1;
      end
    end
  end

  always_comb begin
    out_y = '0;
    for (int i = 0; i < N; i++) begin
      out_y[i*W +: W] = y_q[i];
    end
  end

endmodule

// File: tb/tb_pwl_fma_sched.sv
// Directed bench for pwl_fma_sched with a behavioural half-precision FMA
// of fixed 6-cycle latency that can drop a lane or inject stray results.
module tb_pwl_fma_sched;
  localparam int N  = 10;
  localparam int W  = 16;
  localparam int NW = N * W;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [NW-1:0] in_x = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [NW-1:0] out_y;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_addr = '0;
  logic [15:0]   cfg_k = '0;
  logic [15:0]   cfg_b = '0;
  logic          cfg_busy;
  logic          fma_valid;
  logic [15:0]   fma_a, fma_b, fma_c;
  logic          fma_res_valid;
  logic [15:0]   fma_res;
  logic          err_timeout, err_cfg, err_extra;

  int total = 0;
  int bad   = 0;

  always #5 aclk = ~aclk;

  pwl_fma_sched dut (
    .aclk(aclk), .aresetn(aresetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_k(cfg_k), .cfg_b(cfg_b),
    .cfg_busy(cfg_busy),
    .fma_valid(fma_valid), .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c),
    .fma_res_valid(fma_res_valid), .fma_res(fma_res),
    .err_timeout(err_timeout), .err_cfg(err_cfg), .err_extra(err_extra)
  );

  // ---------------- half-precision FMA model (positive values only)
  function automatic real h2r(input logic [15:0] h);
    real v;
    int  e;
    v = real'(h[9:0]);
    e = int'(h[14:10]);
    if (e != 0) v = v + 1024.0;
    else        e = 1;
    for (int i = 0; i < e; i++)  v = v * 2.0;
    for (int i = 0; i < 25; i++) v = v / 2.0;
    return v;
  endfunction

  function automatic logic [15:0] r2h(input real v);
    real f;
    int  e, m;
    if (v <= 0.0) return 16'h0000;
    f = v;
    e = 15;
    while (f >= 2.0) begin f = f / 2.0; e++; end
    while (f < 1.0 && e > 1) begin f = f * 2.0; e--; end
    if (f < 1.0) begin
      m = $rtoi(f * 1024.0 + 0.5);
      return 16'(m);
    end
    m = $rtoi((f - 1.0) * 1024.0 + 0.5);
    if (m == 1024) begin m = 0; e++; end
    return {1'b0, 5'(e), 10'(m)};
  endfunction

  logic        drop_last = 1'b0;
  logic        inj_valid = 1'b0;
  logic [15:0] inj_data  = '0;
  logic [5:0]  pv = '0;
  logic [15:0] pd [6];

  initial for (int i = 0; i < 6; i++) pd[i] = '0;

  always @(posedge aclk) begin
    pv    <= {pv[4:0], fma_valid && !(drop_last && fma_b == 16'h0009)};
    pd[0] <= r2h(h2r(fma_a) * h2r(fma_b) + h2r(fma_c));
    for (int i = 1; i < 6; i++) pd[i] <= pd[i-1];
  end

  assign fma_res_valid = pv[5] | inj_valid;
  assign fma_res       = inj_valid ? inj_data : pd[5];

  // ---------------- helpers
  task automatic chk(input string tag, input logic [NW-1:0] got, input logic [NW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NW-1:0] seq(input logic [15:0] base);
    logic [NW-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = base + 16'(i);
    return r;
  endfunction

  function automatic logic [NW-1:0] rep(input logic [15:0] v);
    logic [NW-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = v;
    return r;
  endfunction

  task automatic cfg_write(input logic [2:0] a, input logic [15:0] k, input logic [15:0] b);
    cfg_addr = a; cfg_k = k; cfg_b = b; cfg_we = 1'b1;
    @(posedge aclk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic take_out(input string tag);
    out_ready = 1'b1;
    @(posedge aclk); #1;
    out_ready = 1'b0;
    chk({tag, "_ovalid_clr"}, NW'(out_valid), NW'(0));
    chk({tag, "_iready"}, NW'(in_ready), NW'(1));
  endtask

  // Sends one vector, then watches the issue port until out_valid.
  task automatic run_vec(input logic [NW-1:0] x, input logic [NW-1:0] ea,
                         input logic [NW-1:0] ec, output int lat, output int pulses,
                         output int first_t, output int bad_ops);
    int n;
    lat = -1; pulses = 0; first_t = -1; bad_ops = 0; n = 0;
    in_x = x;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin @(posedge aclk); #1; n++; end
    @(posedge aclk); #1;
    in_valid = 1'b0;
    cfg_we = 1'b0;
    for (int t = 1; t <= 300; t++) begin
      @(posedge aclk); #1;
      if (fma_valid) begin
        if (first_t < 0) first_t = t;
        if (t != first_t + pulses) bad_ops++;
        if (pulses < N) begin
          if (fma_b !== x[pulses*W +: W] || fma_a !== ea[pulses*W +: W] ||
              fma_c !== ec[pulses*W +: W]) bad_ops++;
        end else begin
          bad_ops++;
        end
        pulses++;
      end
      if (out_valid) begin lat = t; break; end
    end
  endtask

  // ---------------- test sequence
  logic [NW-1:0] x, ea, ec, ex;
  int lat, pulses, first_t, bad_ops, n, unstable, busy_lo;

  initial begin
    // reset release with in_valid already high
    in_valid = 1'b1;
    repeat (8) @(posedge aclk);
    #1;
    chk("rst_ovalid", NW'(out_valid), NW'(0));
    chk("rst_outy", out_y, '0);
    chk("rst_fma", NW'({fma_valid, fma_a, fma_b, fma_c}), NW'(0));
    chk("rst_errs", NW'({err_timeout, err_cfg, err_extra}), NW'(0));
    aresetn = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      n++;
      inj_valid = (n == 2);
      inj_data  = 16'h1234;
      @(posedge aclk); #1;
    end
    inj_valid = 1'b0;
    in_valid  = 1'b0;
    chk("flush_cycles", NW'(n), NW'(6));
    chk("flush_errs", NW'({err_timeout, err_cfg, err_extra}), NW'(0));
    chk("flush_outy", out_y, '0);
    chk("idle_busy", NW'(cfg_busy), NW'(0));

    // out_ready while nothing is valid has no effect
    out_ready = 1'b1;
    @(posedge aclk); #1;
    out_ready = 1'b0;
    chk("oready_idle", NW'({out_valid, in_ready}), NW'(2'b01));

    // identity segment 0
    cfg_write(3'd0, 16'h3C00, 16'h0000);
    x = seq(16'h0000);
    run_vec(x, rep(16'h3C00), rep(16'h0000), lat, pulses, first_t, bad_ops);
    chk("v1_pulses", NW'(pulses), NW'(10));
    chk("v1_first", NW'(first_t), NW'(1));
    chk("v1_ops", NW'(bad_ops), NW'(0));
    chk("v1_lat", NW'(lat), NW'(17));
    chk("v1_outy", out_y, x);

    // hold in DONE, config write must be rejected
    unstable = 0; busy_lo = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        cfg_addr = 3'd0; cfg_k = 16'h4400; cfg_b = 16'h1234; cfg_we = 1'b1;
      end else begin
        cfg_we = 1'b0;
      end
      @(posedge aclk); #1;
      if (out_y !== x || !out_valid || in_ready) unstable++;
      if (!cfg_busy) busy_lo++;
    end
    cfg_we = 1'b0;
    chk("hold_stable", NW'(unstable), NW'(0));
    chk("hold_busy", NW'(busy_lo), NW'(0));
    chk("hold_errcfg", NW'(err_cfg), NW'(1));
    take_out("v1");

    // segment 5 programmed on the acceptance edge
    x = seq(16'h0010);
    x[15:0] = 16'h1400; x[31:16] = 16'h1600; x[47:32] = 16'h2000;
    ea = rep(16'h3C00); ea[15:0] = 16'h4000; ea[31:16] = 16'h4000;
    ec = rep(16'h0000); ec[15:0] = 16'h3C00; ec[31:16] = 16'h3C00;
    ex = x; ex[15:0] = 16'h3C02; ex[31:16] = 16'h3C03;
    cfg_addr = 3'd5; cfg_k = 16'h4000; cfg_b = 16'h3C00; cfg_we = 1'b1;
    run_vec(x, ea, ec, lat, pulses, first_t, bad_ops);
    chk("v2_ops", NW'(bad_ops), NW'(0));
    chk("v2_lat", NW'(lat), NW'(17));
    chk("v2_outy", out_y, ex);
    take_out("v2");

    // last result lost: timeout with partial vector
    drop_last = 1'b1;
    x = seq(16'h0100); x[159:144] = 16'h0009;
    ex = seq(16'h0100); ex[159:144] = 16'h0019;
    run_vec(x, rep(16'h3C00), rep(16'h0000), lat, pulses, first_t, bad_ops);
    drop_last = 1'b0;
    chk("to_lat", NW'(lat), NW'(80));
    chk("to_err", NW'(err_timeout), NW'(1));
    chk("to_outy", out_y, ex);
    chk("to_noextra", NW'(err_extra), NW'(0));
    inj_valid = 1'b1; inj_data = 16'hBEEF;
    @(posedge aclk); #1;
    inj_valid = 1'b0;
    @(posedge aclk); #1;
    chk("late_extra", NW'(err_extra), NW'(1));
    chk("late_outy", out_y, ex);
    take_out("v3");

    // reset in the middle of ISSUE
    in_x = seq(16'h0200);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge aclk); #1; n++; end
    @(posedge aclk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge aclk);
    #1;
    aresetn = 1'b0;
    @(posedge aclk); #1;
    chk("mid_rst_out", NW'({out_valid, fma_valid, in_ready, cfg_busy}), NW'(4'b0001));
    chk("mid_rst_ops", NW'({fma_a, fma_b, fma_c}), NW'(0));
    chk("mid_rst_outy", out_y, '0);
    chk("mid_rst_errs", NW'({err_timeout, err_cfg, err_extra}), NW'(0));
    aresetn = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin n++; @(posedge aclk); #1; end
    chk("mid_flush", NW'(n), NW'(6));
    chk("mid_stale", NW'({err_extra, out_valid}), NW'(0));
    cfg_write(3'd0, 16'h3C00, 16'h0000);
    x = seq(16'h0300);
    run_vec(x, rep(16'h3C00), rep(16'h0000), lat, pulses, first_t, bad_ops);
    chk("v4_lat", NW'(lat), NW'(17));
    chk("v4_outy", out_y, x);
    chk("v4_errs", NW'({err_timeout, err_cfg, err_extra}), NW'(0));
    take_out("v4");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwl_fma_sched.md
Name: pwl_fma_sched

Overview:
- Scheduler that shares one pipelined half-precision fused multiply-add unit (y = k*x + b) across a 10-lane piecewise-linear exp() stage of the softmax datapath.
- Accepts a vector of N x values and picks each element's segment coefficients (k, b) from an internal table.
- Issues one element per cycle to the FMA, collects the in-order results and presents them as a vector with a valid/ready handshake.

Parameters:
- N, 10, number of lanes per vector.
- W, 16, element width (IEEE half).
- SEG_BITS, 3, log2 of coefficient-table depth (8 segments).
- SEG_LSB, 10, lowest x bit of the segment index field: seg = x[SEG_LSB+SEG_BITS-1:SEG_LSB].
- FMA_LAT, 6, maximum FMA latency in cycles; sets the post-reset flush window.
- TIMEOUT, 64, cycles without a result in DRAIN before err_timeout is flagged.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  synchronous active-low reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  scheduler can accept a vector.
- in_x  in  N*W  x vector; lane i = bits [i*W+W-1:i*W].
- out_valid  out  1  result vector valid.
- out_ready  in  1  consumer accepts the result.
- out_y  out  N*W  result vector, same lane packing.
- cfg_we  in  1  coefficient table write strobe.
- cfg_addr  in  SEG_BITS  table entry.
- cfg_k  in  W  slope.
- cfg_b  in  W  intercept.
- cfg_busy  out  1  high whenever state != IDLE.
- fma_valid  out  1  issue strobe to the FMA.
- fma_a  out  W  k operand.
- fma_b  out  W  x operand.
- fma_c  out  W  b operand.
- fma_res_valid  in  1  FMA result valid (in order, no backpressure).
- fma_res  in  W  FMA result.
- err_timeout  out  1  sticky; cleared only by reset.
- err_cfg  out  1  sticky; cleared only by reset.
- err_extra  out  1  sticky; cleared only by reset.

Behaviour:
- Clock and reset: one clock (aclk); reset is synchronous and active-low (aresetn).
- Reset values: state=FLUSH, flush counter=FMA_LAT, in_ready=0, out_valid=0, out_y=0, fma_valid=0, fma_a/b/c=0, all err flags=0, all 8 table entries k=0/b=0, issue index=0, result count=0.
- FLUSH: fma_res_valid is ignored for FMA_LAT cycles, discarding operations still in flight from before reset. Then go to IDLE. Reset asserted mid-operation always re-enters FLUSH and drops the partial vector.
- IDLE: in_ready=1. When in_valid&&in_ready, latch in_x, set issue index=0 and result count=0, go to ISSUE. The table write is legal only here.
- ISSUE:
  - Each cycle drive fma_valid=1 with fma_b=x[i], fma_a=k[seg(x[i])], fma_c=b[seg(x[i])]. Registered outputs, so lane i appears on the cycle after index=i.
  - Increment i; after lane N-1 go to DRAIN. Issue takes exactly N cycles.
  - fma_valid=0 in every other state.
- Results are counted in ISSUE and DRAIN:
  - Each fma_res_valid writes fma_res into lane[count] of out_y, then count++.
  - When count reaches N, out_valid is set the next cycle and the state goes to DONE. This also holds if the last result arrives while still in ISSUE (FMA latency < N).
- DRAIN timeout: a counter resets on each result. At TIMEOUT cycles without a result, set err_timeout, present the partial vector (missing lanes hold their previous values) with out_valid=1, and go to DONE.
- DONE:
  - out_valid=1 and out_y stay stable until out_ready. On out_valid&&out_ready, clear out_valid and go to IDLE.
  - in_ready=0 (no overlap between vectors).
  - out_ready asserted while out_valid=0 has no effect.
- Extra results: fma_res_valid in IDLE or DONE, or after count==N, is dropped and sets err_extra.
- Config writes:
  - cfg_we in IDLE writes k/b at cfg_addr on that edge.
  - cfg_we outside IDLE is dropped and sets err_cfg.
  - A write in the same cycle as vector acceptance is applied, and the accepted vector uses the updated table.
- Segment index is a raw bit field of x: no clamping and no sign handling. The table is programmed to cover all 2^SEG_BITS values.
- Latency: vector acceptance to out_valid = N + FMA latency + 1 cycles.

Test Plan:
- Reset release, in_valid=1 immediately -> in_ready stays 0 for FMA_LAT cycles; a fma_res_valid pulse during this window changes nothing and sets no error.
- Program entry 0 with k=0x3C00 (1.0) and b=0x0000; send x lanes 0x0000..0x0009 with an ideal FMA model of latency 6 -> exactly 10 consecutive fma_valid pulses with fma_a=0x3C00 and fma_c=0; out_valid rises 17 cycles after acceptance; out_y equals in_x.
- Program entry 5 with k=0x4000 and b=0x3C00; a lane with x=0x1400 (bits 12:10 = 5) -> fma_a=0x4000, fma_c=0x3C00; result lane = 0x3C00 + 2x per the model.
- Hold out_ready=0 for 20 cycles in DONE -> out_y stable, in_ready=0; a cfg_we in this window sets err_cfg and the table is unchanged.
- Model drops the last result -> after TIMEOUT=64 idle cycles err_timeout=1, out_valid=1 with 9 valid lanes; a late result then sets err_extra.
- Assert aresetn=0 for one cycle mid-ISSUE -> all outputs return to reset values; a stale result within FMA_LAT cycles is ignored; the next vector completes correctly.
